affine_schedule_ctrl: RTL and testbench

- Generates the enable and 3-D loop-index (`ctrl_vars`) stream that drives one port of a unified buffer, either a `*_write_wen`/`*_write_ctrl_vars` pair or a `*_read_ren`/`*_read_ctrl_vars` pair.
- Walks a perfect 3-deep loop nest `[d0][d1][d2]` (d2 innermost) with a programmable initiation interval and start delay, from flush to done.
- One instance per buffer port. For example, the up_sample output side instantiates it with extents 1×128×128 to drive the `nearest_neighbor_stencil` write port.

---
 rtl/affine_schedule_ctrl_if.sv | 30 +++
 rtl/affine_schedule_ctrl.sv | 120 ++++++++++++
 tb/tb_affine_schedule_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/affine_schedule_ctrl_if.sv
// Port bundle between an affine schedule controller and one unified-buffer port:
// restart/backpressure in, enable plus 3-D loop indices and status out.
interface affine_schedule_ctrl_if #(
  parameter int W = 16
);
  logic             flush;
  logic             stall;
  logic             op_en;
  logic [2:0][W-1:0] ctrl_vars;
  logic             busy;
  logic             done;

  modport master (
    input  flush,
    input  stall,
    output op_en,
    output ctrl_vars,
    output busy,
    output done
  );

  modport slave (
    output flush,
    output stall,
    input  op_en,
    input  ctrl_vars,
    input  busy,
    input  done
  );
endinterface

// File: rtl/affine_schedule_ctrl.sv
// Walks a perfect [d0][d1][d2] loop nest with programmable initiation interval and
// start delay, producing the buffer-port enable and the index of each firing iteration.
module affine_schedule_ctrl #(
  parameter int W           = 16,
  parameter int EXT0        = 1,
  parameter int EXT1        = 128,
  parameter int EXT2        = 128,
  parameter int II          = 1,
  parameter int START_DELAY = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  affine_schedule_ctrl_if.master sif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Bounds are held as EXTn-1 so an extent of 2^W still fits in W bits.
  localparam logic [W-1:0] ZERO_W     = {W{1'b0}};
  localparam logic [W-1:0] ONE_W      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST0      = W'(EXT0 - 1);
  localparam logic [W-1:0] LAST1      = W'(EXT1 - 1);
  localparam logic [W-1:0] LAST2      = W'(EXT2 - 1);
  localparam logic [W-1:0] II_LAST    = W'(II - 1);
  localparam logic [31:0]  DELAY_LAST = 32'(START_DELAY - 1);
  localparam bit           HAS_DELAY  = (START_DELAY != 32'sd0);

  state_e            state_q, state_d;
  logic [2:0][W-1:0] idx_q, idx_d;
  logic [W-1:0]      ii_cnt_q, ii_cnt_d;
  logic [31:0]       delay_cnt_q, delay_cnt_d;
  logic              fire_s;
  logic              at_last_s;

  assign fire_s    = (state_q == S_RUN) && (ii_cnt_q == ZERO_W) && !sif.stall;
  assign at_last_s = (idx_q[0] == LAST0) && (idx_q[1] == LAST1) && (idx_q[2] == LAST2);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ii_cnt_d    = ii_cnt_q;
    delay_cnt_d = delay_cnt_q;
    if (sif.flush) begin
      idx_d       = {3{ZERO_W}};
      ii_cnt_d    = ZERO_W;
      delay_cnt_d = 32'd0;
      state_d     = HAS_DELAY ? S_DELAY : S_RUN;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_DELAY: begin
          delay_cnt_d = delay_cnt_q + 32'd1;
          if (delay_cnt_q == DELAY_LAST) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DELAY;
          end
        end
        S_RUN: begin
          if (fire_s) begin
            ii_cnt_d = (II_LAST == ZERO_W) ? ZERO_W : ONE_W;
            // The final iteration keeps its indices on the outputs instead of wrapping.
            if (at_last_s) begin
              state_d = S_DONE;
            end else if (idx_q[2] != LAST2) begin
              idx_d[2] = idx_q[2] + ONE_W;
            end else if (idx_q[1] != LAST1) begin
              idx_d[2] = ZERO_W;
              idx_d[1] = idx_q[1] + ONE_W;
            end else begin
              idx_d[2] = ZERO_W;
              idx_d[1] = ZERO_W;
              idx_d[0] = idx_q[0] + ONE_W;
            end
          end else if (ii_cnt_q == ZERO_W) begin
            ii_cnt_d = ZERO_W;
          end else if (ii_cnt_q == II_LAST) begin
            ii_cnt_d = ZERO_W;
          end else begin
            ii_cnt_d = ii_cnt_q + ONE_W;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, index, interval and delay registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= {3{ZERO_W}};
      ii_cnt_q    <= ZERO_W;
      delay_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ii_cnt_q    <= ii_cnt_d;
      delay_cnt_q <= delay_cnt_d;
    end
  end

  assign sif.op_en     = fire_s;
  assign sif.ctrl_vars = idx_q;
  assign sif.busy      = (state_q == S_DELAY) || (state_q == S_RUN);
  assign sif.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_affine_schedule_ctrl.sv
// Randomized self-checking bench: three schedule controllers (default, 2x2x3 with
// interval and delay, 1x1x1) compared cycle by cycle against a linear-iteration model.
module tb_affine_schedule_ctrl;

  logic clk;
  logic rst_n;
  logic flush_r [3];
  logic stall_r [3];
  logic op_s    [3];
  logic busy_s  [3];
  logic done_s  [3];
  logic [2:0][15:0] cv_s [3];

  int n_checks;
  int n_fail;

  affine_schedule_ctrl_if #(.W(16)) if_a ();
  affine_schedule_ctrl_if #(.W(16)) if_b ();
  affine_schedule_ctrl_if #(.W(16)) if_c ();

  affine_schedule_ctrl #(.W(16), .EXT0(1), .EXT1(128), .EXT2(128), .II(1), .START_DELAY(0))
    u_dut_a (.clk(clk), .rst_n(rst_n), .sif(if_a));
  affine_schedule_ctrl #(.W(16), .EXT0(2), .EXT1(2), .EXT2(3), .II(2), .START_DELAY(5))
    u_dut_b (.clk(clk), .rst_n(rst_n), .sif(if_b));
  affine_schedule_ctrl #(.W(16), .EXT0(1), .EXT1(1), .EXT2(1), .II(1), .START_DELAY(0))
    u_dut_c (.clk(clk), .rst_n(rst_n), .sif(if_c));

  assign if_a.flush = flush_r[0];
  assign if_a.stall = stall_r[0];
  assign if_b.flush = flush_r[1];
  assign if_b.stall = stall_r[1];
  assign if_c.flush = flush_r[2];
  assign if_c.stall = stall_r[2];

  assign op_s[0] = if_a.op_en;
  assign op_s[1] = if_b.op_en;
  assign op_s[2] = if_c.op_en;
  assign busy_s[0] = if_a.busy;
  assign busy_s[1] = if_b.busy;
  assign busy_s[2] = if_c.busy;
  assign done_s[0] = if_a.done;
  assign done_s[1] = if_b.done;
  assign done_s[2] = if_c.done;
  assign cv_s[0] = if_a.ctrl_vars;
  assign cv_s[1] = if_b.ctrl_vars;
  assign cv_s[2] = if_c.ctrl_vars;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loop indices of linear iteration k in a row-major e0 x e1 x e2 nest.
  function automatic logic [2:0][15:0] idx3(input int k, input int e1, input int e2);
    logic [2:0][15:0] r;
    r[0] = 16'(k / (e1 * e2));
    r[1] = 16'((k / e2) % e1);
    r[2] = 16'(k % e2);
    return r;
  endfunction

  // Entered at a negedge: flushes instance i, then checks every cycle until the
  // schedule is done plus 'post' cycles, or returns at iteration abort_k (still in RUN).
  task automatic run_sched(input int i, input int e0, input int e1, input int e2,
                           input int ii, input int sd, input int rnd_pct,
                           input int st_k, input int st_len, input int abort_k, input int post);
    int n, k, wait_c, g, st_done, cyc, pulses, post_cnt, budget;
    logic s, exp_op, exp_busy, exp_done;
    logic [2:0][15:0] exp_cv;
    n = e0 * e1 * e2;
    k = 0; wait_c = sd; g = 0; st_done = 0; cyc = 0; pulses = 0; post_cnt = 0;
    budget = 2 * n * ii + sd + post + 200;
    flush_r[i] = 1'b1;
    stall_r[i] = 1'b0;
    @(negedge clk);
    flush_r[i] = 1'b0;
    while (post_cnt <= post) begin
      if (abort_k >= 0 && k == abort_k && wait_c == 0) begin
        check_val($sformatf("u%0d.abort_idx", i), 64'(cv_s[i]), 64'(idx3(k, e1, e2)));
        stall_r[i] = 1'b0;
        return;
      end
      if (wait_c == 0 && k == st_k && st_done < st_len) begin
        s = 1'b1;
        st_done++;
      end else begin
        s = ($urandom_range(99) < rnd_pct) ? 1'b1 : 1'b0;
      end
      stall_r[i] = s;
      #1;
      exp_cv = idx3((k < n) ? k : n - 1, e1, e2);
      if (wait_c > 0) begin
        exp_op = 1'b0; exp_busy = 1'b1; exp_done = 1'b0;
      end else if (k < n) begin
        exp_op = (g == 0) && !s; exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        exp_op = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
      end
      check_val($sformatf("u%0d.op_en@%0d", i, k), 64'(op_s[i]), 64'(exp_op));
      check_val($sformatf("u%0d.ctrl_vars@%0d", i, k), 64'(cv_s[i]), 64'(exp_cv));
      check_val($sformatf("u%0d.busy@%0d", i, k), 64'(busy_s[i]), 64'(exp_busy));
      check_val($sformatf("u%0d.done@%0d", i, k), 64'(done_s[i]), 64'(exp_done));
      if (op_s[i] === 1'b1) pulses++;
      if (wait_c > 0) begin
        wait_c--;
      end else if (k < n) begin
        if (exp_op) begin
          k++;
          g = ii - 1;
        end else if (g > 0) begin
          g--;
        end
      end else begin
        post_cnt++;
      end
      @(negedge clk);
      cyc++;
      if (cyc > budget) begin
        check_val($sformatf("u%0d.timeout", i), 64'(cyc), 64'(budget));
        break;
      end
    end
    stall_r[i] = 1'b0;
    check_val($sformatf("u%0d.pulses", i), 64'(pulses), 64'(n));
  endtask

  task automatic check_idle(input string tag);
    for (int j = 0; j < 3; j++) begin
      check_val($sformatf("%s.u%0d.op_en", tag, j), 64'(op_s[j]), 64'd0);
      check_val($sformatf("%s.u%0d.busy", tag, j), 64'(busy_s[j]), 64'd0);
      check_val($sformatf("%s.u%0d.done", tag, j), 64'(done_s[j]), 64'd0);
      check_val($sformatf("%s.u%0d.ctrl_vars", tag, j), 64'(cv_s[j]), 64'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    for (int j = 0; j < 3; j++) begin
      flush_r[j] = 1'b0;
      stall_r[j] = 1'b0;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      stall_r[0] = 1'(c == 1);
      #1 check_idle("idle");
      @(negedge clk);
    end
    stall_r[0] = 1'b0;

    // Defaults, no stall: 16384 back-to-back pulses then done.
    run_sched(0, 1, 128, 128, 1, 0, 0, -1, 0, -1, 3);
    // 2x2x3, interval 2, start delay 5.
    run_sched(1, 2, 2, 3, 2, 5, 0, -1, 0, -1, 3);
    // Degenerate 1x1x1 with random stall while done.
    run_sched(2, 1, 1, 1, 1, 0, 0, -1, 0, -1, 8);
    run_sched(2, 1, 1, 1, 1, 0, 50, -1, 0, -1, 8);
    // Seven-cycle stall at (0,0,5), plus sparse random stalls.
    run_sched(0, 1, 128, 128, 1, 0, 3, 5, 7, -1, 3);
    // Flush at (0,3,17), then a full restarted run.
    run_sched(0, 1, 128, 128, 1, 0, 0, -1, 0, 3 * 128 + 17, 0);
    run_sched(0, 1, 128, 128, 1, 0, 0, -1, 0, -1, 3);

    // Asynchronous reset mid-run, applied between clock edges.
    run_sched(0, 1, 128, 128, 1, 0, 0, -1, 0, 100, 0);
    #1;
    check_val("pre_rst.op_en", 64'(op_s[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check_idle("post_rst");
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
